// File: rtl/ff_bist_ctrl.sv
// ff_bist_ctrl: BIST sequencer for the SR/JK/D/T flip-flop bank.
// Pulses the bank reset, then applies NUM_VEC LFSR vectors and checks every response.
// A golden model tracks the bank; results are error count, sticky cell mask and pass.
// Optional macro FF_BIST_STOP_ON_FAIL_EN ends the run at the first failing vector.
module ff_bist_ctrl #(
  parameter int unsigned NUM_VEC = 16,
  parameter logic [5:0]  SEED    = 6'h2D,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q_sr,
  input  logic             q_jk,
  input  logic             q_d,
  input  logic             q_t,
  output logic             ff_rst,
  output logic             S,
  output logic             R,
  output logic             J,
  output logic             K,
  output logic             Din,
  output logic             T,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       fail_mask,
  output logic [7:0]       vec_idx
);

  typedef enum logic [2:0] {IDLE, INIT, APPLY, CHECK, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [5:0]       SEED_EFF = (SEED == 6'd0) ? 6'h01 : SEED;
  localparam logic [7:0]       LAST_IDX = 8'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [5:0]       lfsr_q, lfsr_d;
  logic [5:0]       bank_in_q, bank_in_d;   // {T, Din, K, J, R, S}
  logic [3:0]       gold_q, gold_d;         // {T, D, JK, SR}
  logic             ff_rst_q, ff_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic [7:0]       vec_idx_q, vec_idx_d;
  logic [3:0]       mism;
  logic             last_vec;

  // S and R are never both high: R is masked whenever S is set.
  function automatic logic [5:0] map_vec(input logic [5:0] l);
    return {l[5], l[4], l[3], l[2], l[1] & ~l[0], l[0]};
  endfunction

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  // One clock of the four reference cells for the given bank inputs.
  function automatic logic [3:0] gold_next(input logic [3:0] g, input logic [5:0] v);
    logic sr, jk;
    if (v[0])      sr = 1'b1;
    else if (v[1]) sr = 1'b0;
    else           sr = g[0];
    case ({v[2], v[3]})
      2'b10:   jk = 1'b1;
      2'b01:   jk = 1'b0;
      2'b11:   jk = ~g[1];
      default: jk = g[1];
    endcase
    return {g[3] ^ v[5], v[4], jk, sr};
  endfunction

  assign mism = {q_t, q_d, q_jk, q_sr} ^ gold_q;

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    bank_in_d   = bank_in_q;
    gold_d      = gold_q;
    ff_rst_d    = ff_rst_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fail_mask_d = fail_mask_q;
    vec_idx_d   = vec_idx_q;
    last_vec    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = INIT;
          lfsr_d      = SEED_EFF;
          bank_in_d   = '0;
          gold_d      = '0;
          ff_rst_d    = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          fail_mask_d = '0;
          vec_idx_d   = '0;
        end
      end
      INIT: begin
        state_d   = APPLY;
        ff_rst_d  = 1'b0;
        bank_in_d = map_vec(lfsr_q);
      end
      APPLY: begin
        state_d = CHECK;
        gold_d  = gold_next(gold_q, bank_in_q);
      end
      CHECK: begin
        // The bank has no enable: it clocks the held vector again on this
        // edge, so the golden model does too (matters for JK=11 and T=1).
        gold_d = gold_next(gold_q, bank_in_q);
        lfsr_d = lfsr_step(lfsr_q);
        if (|mism) begin
          err_cnt_d   = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
          fail_mask_d = fail_mask_q | mism;
        end
        last_vec = (vec_idx_q == LAST_IDX);
`ifdef FF_BIST_STOP_ON_FAIL_EN
        last_vec = last_vec | (|mism);
`endif
        if (last_vec) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d   = APPLY;
          vec_idx_d = vec_idx_q + 8'd1;
          bank_in_d = map_vec(lfsr_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any run and clears all results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      bank_in_q   <= '0;
      gold_q      <= '0;
      ff_rst_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_mask_q <= '0;
      vec_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      bank_in_q   <= bank_in_d;
      gold_q      <= gold_d;
      ff_rst_q    <= ff_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_mask_q <= fail_mask_d;
      vec_idx_q   <= vec_idx_d;
    end
  end

  assign {T, Din, K, J, R, S} = bank_in_q;
  assign ff_rst    = ff_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_mask = fail_mask_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_ff_bist_ctrl.sv
// tb_ff_bist_ctrl: drives two sequencers (CNT_W=8 and CNT_W=2, both SEED=1, NUM_VEC=16)
// against behavioural flip-flop banks with selectable per-cell faults
// (0 good, 1 stuck-0, 2 stuck-1, 3 inverted) and a spec-level run model.
module tb_ff_bist_ctrl;

`ifdef FF_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif
  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [7:0] fm_a = 8'h00, fm_b = 8'h00;
  logic [3:0] bk_a = 4'h0, bk_b = 4'h0;   // {T, D, JK, SR}

  logic q_sr_a, q_jk_a, q_d_a, q_t_a, q_sr_b, q_jk_b, q_d_b, q_t_b;
  logic ff_rst_a, S_a, R_a, J_a, K_a, Din_a, T_a, busy_a, done_a, pass_a;
  logic ff_rst_b, S_b, R_b, J_b, K_b, Din_b, T_b, busy_b, done_b, pass_b;
  logic [7:0] err_cnt_a, vec_idx_a, vec_idx_b;
  logic [1:0] err_cnt_b;
  logic [3:0] fail_mask_a, fail_mask_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Cell characteristic equations, v = {T, Din, K, J, R, S}.
  function automatic logic [3:0] cell_next(input logic [3:0] b, input logic [5:0] v);
    logic [3:0] n;
    n[0] = v[0] | (b[0] & ~v[1]);
    n[1] = (v[2] & ~b[1]) | (~v[3] & b[1]);
    n[2] = v[4];
    n[3] = b[3] ^ v[5];
    return n;
  endfunction

  function automatic logic flt(input logic [1:0] m, input logic v);
    case (m)
      2'd0:    return v;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ~v;
    endcase
  endfunction

  function automatic logic [5:0] vec_of(input logic [5:0] l);
    return {l[5], l[4], l[3], l[2], l[1] & ~l[0], l[0]};
  endfunction

  // Expected run result: the bank clocks each vector twice (APPLY and CHECK
  // edges) and is observed after the first capture.
  function automatic void ref_run(input logic [7:0] fm, input int cnt_w,
                                  output int e_err, output logic [3:0] e_mask,
                                  output int e_last);
    logic [5:0] l;
    logic [3:0] b, mm;
    int raw, mx;
    l = 6'h01; b = 4'h0; raw = 0; e_mask = 4'h0; e_last = NV - 1;
    mx = (1 << cnt_w) - 1;
    for (int i = 0; i < NV; i++) begin
      b = cell_next(b, vec_of(l));
      mm = 4'h0;
      for (int c = 0; c < 4; c++) mm[c] = (flt(fm[2*c +: 2], b[c]) != b[c]);
      b = cell_next(b, vec_of(l));
      if (mm != 4'h0) begin
        raw++;
        e_mask = e_mask | mm;
        if (STOP_EN) begin
          e_last = i;
          break;
        end
      end
      l = {l[4:0], l[5] ^ l[4]};
    end
    e_err = (raw > mx) ? mx : raw;
  endfunction

  assign q_sr_a = flt(fm_a[1:0], bk_a[0]);
  assign q_jk_a = flt(fm_a[3:2], bk_a[1]);
  assign q_d_a  = flt(fm_a[5:4], bk_a[2]);
  assign q_t_a  = flt(fm_a[7:6], bk_a[3]);
  assign q_sr_b = flt(fm_b[1:0], bk_b[0]);
  assign q_jk_b = flt(fm_b[3:2], bk_b[1]);
  assign q_d_b  = flt(fm_b[5:4], bk_b[2]);
  assign q_t_b  = flt(fm_b[7:6], bk_b[3]);

  always @(posedge clk) begin
    bk_a <= ff_rst_a ? 4'h0 : cell_next(bk_a, {T_a, Din_a, K_a, J_a, R_a, S_a});
    bk_b <= ff_rst_b ? 4'h0 : cell_next(bk_b, {T_b, Din_b, K_b, J_b, R_b, S_b});
  end

  ff_bist_ctrl #(.NUM_VEC(NV), .SEED(6'h01), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .q_sr(q_sr_a), .q_jk(q_jk_a), .q_d(q_d_a), .q_t(q_t_a),
    .ff_rst(ff_rst_a), .S(S_a), .R(R_a), .J(J_a), .K(K_a), .Din(Din_a), .T(T_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_cnt_a), .fail_mask(fail_mask_a), .vec_idx(vec_idx_a)
  );

  ff_bist_ctrl #(.NUM_VEC(NV), .SEED(6'h01), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .q_sr(q_sr_b), .q_jk(q_jk_b), .q_d(q_d_b), .q_t(q_t_b),
    .ff_rst(ff_rst_b), .S(S_b), .R(R_b), .J(J_b), .K(K_b), .Din(Din_b), .T(T_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_cnt_b), .fail_mask(fail_mask_b), .vec_idx(vec_idx_b)
  );

  // Full run on dut_a with per-cycle checks; poke>=0 pulses start during APPLY of that vector.
  task automatic drive_run_a(input logic [7:0] fm, input int poke);
    int e_err, e_last;
    logic [3:0] e_mask;
    logic [5:0] l;
    fm_a = fm;
    ref_run(fm, 8, e_err, e_mask, e_last);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    total++;
    if ({ff_rst_a, busy_a, done_a, pass_a, T_a, Din_a, K_a, J_a, R_a, S_a} !== 10'b1100_000000) begin
      bad++;
      $display("FAIL init: got rst/busy/done/pass/vec=%b want 1100000000",
               {ff_rst_a, busy_a, done_a, pass_a, T_a, Din_a, K_a, J_a, R_a, S_a});
    end
    l = 6'h01;
    for (int i = 0; i <= e_last; i++) begin
      @(negedge clk);
      start_a = (poke == i);
      total++;
      if ({ff_rst_a, busy_a, done_a, vec_idx_a, T_a, Din_a, K_a, J_a, R_a, S_a} !==
          {3'b010, 8'(i), vec_of(l)}) begin
        bad++;
        $display("FAIL apply[%0d]: got ctl=%b idx=%0d vec=%b want ctl=010 idx=%0d vec=%b", i,
                 {ff_rst_a, busy_a, done_a}, vec_idx_a, {T_a, Din_a, K_a, J_a, R_a, S_a}, i, vec_of(l));
      end
      @(negedge clk);
      start_a = 1'b0;
      total++;
      if ({ff_rst_a, busy_a, done_a, vec_idx_a, T_a, Din_a, K_a, J_a, R_a, S_a} !==
          {3'b010, 8'(i), vec_of(l)}) begin
        bad++;
        $display("FAIL check[%0d]: got ctl=%b idx=%0d vec=%b want ctl=010 idx=%0d vec=%b", i,
                 {ff_rst_a, busy_a, done_a}, vec_idx_a, {T_a, Din_a, K_a, J_a, R_a, S_a}, i, vec_of(l));
      end
      l = {l[4:0], l[5] ^ l[4]};
    end
    @(negedge clk);
    total++;
    if ({busy_a, done_a, pass_a, err_cnt_a, fail_mask_a, vec_idx_a} !==
        {2'b01, (e_err == 0), 8'(e_err), e_mask, 8'(e_last)}) begin
      bad++;
      $display("FAIL result fm=%h: got b/d/p=%b err=%0d mask=%b idx=%0d want b/d/p=01%b err=%0d mask=%b idx=%0d",
               fm, {busy_a, done_a, pass_a}, err_cnt_a, fail_mask_a, vec_idx_a,
               (e_err == 0), e_err, e_mask, e_last);
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({ff_rst_a, S_a, R_a, J_a, K_a, Din_a, T_a, busy_a, done_a, pass_a, err_cnt_a, fail_mask_a, vec_idx_a} !== '0) begin
      bad++;
      $display("FAIL reset_a: outputs not all zero (busy=%b err=%0d idx=%0d)", busy_a, err_cnt_a, vec_idx_a);
    end
    total++;
    if ({ff_rst_b, S_b, R_b, J_b, K_b, Din_b, T_b, busy_b, done_b, pass_b, err_cnt_b, fail_mask_b, vec_idx_b} !== '0) begin
      bad++;
      $display("FAIL reset_b: outputs not all zero (busy=%b err=%0d idx=%0d)", busy_b, err_cnt_b, vec_idx_b);
    end
    start_a = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_a, ff_rst_a} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: got busy/ff_rst=%b want 00", {busy_a, ff_rst_a});
    end
    start_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_run;
    drive_run_a(8'h00, -1);
  endtask

  task automatic test_stuck_sr;
    int e_err, e_last;
    logic [3:0] e_mask;
    ref_run(8'h01, 8, e_err, e_mask, e_last);
    total++;
    if (e_mask !== 4'b0001 || e_err < 1) begin
      bad++;
      $display("FAIL stuck_sr_model: got mask=%b err=%0d want mask=0001 err>=1", e_mask, e_err);
    end
    drive_run_a(8'h01, -1);
  endtask

  task automatic test_reset_mid_run;
    fm_a = 8'h00;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (11) @(negedge clk);
    total++;
    if ({busy_a, vec_idx_a} !== {1'b1, 8'd5}) begin
      bad++;
      $display("FAIL pre_abort: got busy=%b idx=%0d want busy=1 idx=5", busy_a, vec_idx_a);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({ff_rst_a, S_a, R_a, J_a, K_a, Din_a, T_a, busy_a, done_a, pass_a, err_cnt_a, fail_mask_a, vec_idx_a} !== '0) begin
      bad++;
      $display("FAIL abort: outputs not zero (busy=%b S=%b idx=%0d)", busy_a, S_a, vec_idx_a);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_run_a(8'h00, -1);
  endtask

  task automatic test_saturation;
    int e_err, e_last, cyc;
    logic [3:0] e_mask;
    fm_b = 8'hFF;
    ref_run(8'hFF, 2, e_err, e_mask, e_last);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (busy_b === 1'b1 && cyc < 200) begin
      cyc++;
      start_b = (cyc == 2);
      @(negedge clk);
    end
    start_b = 1'b0;
    total++;
    if (cyc != 1 + 2 * (e_last + 1)) begin
      bad++;
      $display("FAIL sat_busy: got %0d cycles want %0d", cyc, 1 + 2 * (e_last + 1));
    end
    total++;
    if ({done_b, pass_b, err_cnt_b, fail_mask_b} !== {2'b10, 2'(e_err), e_mask}) begin
      bad++;
      $display("FAIL sat_result: got d/p=%b err=%0d mask=%b want d/p=10 err=%0d mask=%b",
               {done_b, pass_b}, err_cnt_b, fail_mask_b, e_err, e_mask);
    end
  endtask

  task automatic test_back_to_back;
    drive_run_a(8'h30, 3);
    drive_run_a(8'h00, 7);
  endtask

  task automatic test_random_faults;
    logic [7:0] fm;
    for (int r = 0; r < 8; r++) begin
      fm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_run_a(fm, $urandom_range(0, 20));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_run();
    test_stuck_sr();
    test_reset_mid_run();
    test_saturation();
    test_back_to_back();
    test_random_faults();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
